// File: rtl/code_lock_pkg.sv
// Shared state encoding and LED colour constants for the two-button code lock.
// LED bits are active-low: bit2 = red, bit1 = blue, bit0 = green.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ENROLL  = 3'd0,
        VERIFY  = 3'd1,
        GRANTED = 3'd2,
        DENIED  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam logic [2:0] LED_OFF   = 3'b111;
    localparam logic [2:0] LED_RED   = 3'b011;
    localparam logic [2:0] LED_BLUE  = 3'b101;
    localparam logic [2:0] LED_GREEN = 3'b110;
    localparam logic [2:0] LED_CYAN  = 3'b100;

endpackage

// File: rtl/code_lock_button_event.sv
// Synchronises both active-low buttons and emits one event per press.
// Re-arming requires both buttons released, so a held or rolled press counts once.
module button_event (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a_n,
    input  logic btn_b_n,
    output logic ev_valid,
    output logic ev_bit
);

    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic       armed;
    logic       a_s;
    logic       b_s;
    logic       one_low;

    always_comb begin
        a_s     = sync_a[1];
        b_s     = sync_b[1];
        one_low = a_s ^ b_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a   <= '1;
            sync_b   <= '1;
            armed    <= 1'b1;
            ev_valid <= 1'b0;
            ev_bit   <= 1'b0;
        end else begin
            sync_a   <= {sync_a[0], btn_a_n};
            sync_b   <= {sync_b[0], btn_b_n};
            ev_valid <= armed && one_low;
            ev_bit   <= ~b_s;
            if (armed && one_low) begin
                armed <= 1'b0;
            end else if (a_s && b_s) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/code_lock_sequencer.sv
// Code lock controller: enrol, verify, grant, deny and lockout phases with a
// shared down-counter for all timeouts and a blink phase for the status LED.
module code_lock_sequencer
    import code_lock_pkg::*;
#(
    parameter int CODE_LEN       = 6,
    parameter int MAX_FAILS      = 3,
    parameter int BLINK_HALF     = 10_000_000,
    parameter int DENY_CYCLES    = 20_000_000,
    parameter int LOCKOUT_CYCLES = 200_000_000,
    parameter int IDLE_CYCLES    = 100_000_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             btn_a_n,
    input  logic                             btn_b_n,
    output logic [2:0]                       led,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic [2:0]                       state_dbg
);

    localparam int CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [31:0] T_IDLE     = 32'(IDLE_CYCLES - 1);
    localparam logic [31:0] T_DENY     = 32'(DENY_CYCLES - 1);
    localparam logic [31:0] T_LOCK     = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       bit_cnt;
    logic [CODE_LEN-1:0] code;
    logic [CODE_LEN-1:0] entry;
    logic [CODE_LEN-1:0] bit_sel;
    logic [CODE_LEN-1:0] new_entry;
    logic [CODE_LEN-1:0] new_code;
    logic [31:0]         timer;
    logic [31:0]         blink_cnt;
    logic                blink_on;
    logic [FW-1:0]       fail_inc;
    logic                ev_valid;
    logic                ev_bit;
    logic                last_bit;
    logic                timer_done;
    logic                idle_expire;
    logic                state_change;
    logic                code_match;
    logic [2:0]          led_d;
    logic                unlocked_d;
    logic                locked_d;

    button_event u_evt (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_a_n  (btn_a_n),
        .btn_b_n  (btn_b_n),
        .ev_valid (ev_valid),
        .ev_bit   (ev_bit)
    );

    assign state_dbg = state;

    // The last bit is merged before comparing, so the match never sees a stale entry.
    always_comb begin
        bit_sel = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            bit_sel[i] = (bit_cnt == CW'(i));
        end
        new_entry   = (entry & ~bit_sel) | ({CODE_LEN{ev_bit}} & bit_sel);
        new_code    = (code & ~bit_sel) | ({CODE_LEN{ev_bit}} & bit_sel);
        code_match  = (new_entry == code);
        last_bit    = (bit_cnt == CW'(CODE_LEN - 1));
        timer_done  = (timer == '0);
        idle_expire = timer_done && (bit_cnt != '0);
        fail_inc    = fail_count + FW'(1);
    end

    always_comb begin
        next_state = state;
        case (state)
            ENROLL:  if (ev_valid && last_bit) next_state = VERIFY;
            VERIFY: begin
                if (ev_valid && last_bit) begin
                    if (code_match)                      next_state = GRANTED;
                    else if (fail_inc == FW'(MAX_FAILS)) next_state = LOCKOUT;
                    else                                 next_state = DENIED;
                end
            end
            GRANTED: if (ev_valid)   next_state = VERIFY;
            DENIED:  if (timer_done) next_state = VERIFY;
            LOCKOUT: if (timer_done) next_state = VERIFY;
            default: next_state = ENROLL;
        endcase
        state_change = (next_state != state);
    end

    always_comb begin
        led_d      = LED_OFF;
        unlocked_d = 1'b0;
        locked_d   = 1'b0;
        case (state)
            ENROLL:  led_d = blink_on ? LED_BLUE : LED_OFF;
            VERIFY:  led_d = blink_on ? LED_CYAN : LED_OFF;
            GRANTED: begin
                led_d      = LED_GREEN;
                unlocked_d = 1'b1;
            end
            DENIED:  led_d = LED_RED;
            LOCKOUT: begin
                led_d    = blink_on ? LED_RED : LED_OFF;
                locked_d = 1'b1;
            end
            default: led_d = LED_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ENROLL;
            bit_cnt    <= '0;
            code       <= '0;
            entry      <= '0;
            fail_count <= '0;
            timer      <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            led        <= LED_OFF;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= next_state;
            led        <= led_d;
            unlocked   <= unlocked_d;
            locked_out <= locked_d;

            if (state_change) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt >= BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end

            if (state_change) begin
                case (next_state)
                    DENIED:  timer <= T_DENY;
                    LOCKOUT: timer <= T_LOCK;
                    default: timer <= T_IDLE;
                endcase
            end else if (ev_valid && (state == ENROLL || state == VERIFY)) begin
                timer <= T_IDLE;
            end else if (!timer_done) begin
                timer <= timer - 32'd1;
            end

            case (state)
                ENROLL: begin
                    if (ev_valid) begin
                        code    <= new_code;
                        bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
                    end else if (idle_expire) begin
                        bit_cnt <= '0;
                        entry   <= '0;
                    end
                end
                VERIFY: begin
                    if (ev_valid) begin
                        if (last_bit) begin
                            bit_cnt    <= '0;
                            entry      <= '0;
                            fail_count <= code_match ? '0 : fail_inc;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                            entry   <= new_entry;
                        end
                    end else if (idle_expire) begin
                        bit_cnt <= '0;
                        entry   <= '0;
                    end
                end
                GRANTED: begin
                    if (ev_valid) begin
                        bit_cnt <= '0;
                        entry   <= '0;
                    end
                end
                LOCKOUT: begin
                    if (timer_done) fail_count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_sequencer.sv
// Directed bench for the code lock: reset, enrolment blink, a table of
// entry/press/idle steps, then hand-written deny, hygiene, timeout and reset cases.
module tb_code_lock_sequencer;
    import code_lock_pkg::*;

    localparam int CODE_LEN       = 6;
    localparam int MAX_FAILS      = 3;
    localparam int BLINK_HALF     = 4;
    localparam int DENY_CYCLES    = 8;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int IDLE_CYCLES    = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_a_n;
    logic       btn_b_n;
    logic [2:0] led;
    logic       unlocked;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int ev_count = 0;
    int red_cnt = 0;
    bit measure = 1'b0;
    int e0;

    typedef struct {
        int         kind;     // 0 = enter code, 1 = single press of val[0], 2 = idle 8 cycles
        logic [5:0] val;
        int         st;
        int         unl;
        int         lo;
        int         fc;
        bit         led_chk;
        logic [2:0] led;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    code_lock_sequencer #(
        .CODE_LEN       (CODE_LEN),
        .MAX_FAILS      (MAX_FAILS),
        .BLINK_HALF     (BLINK_HALF),
        .DENY_CYCLES    (DENY_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .IDLE_CYCLES    (IDLE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_a_n    (btn_a_n),
        .btn_b_n    (btn_b_n),
        .led        (led),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_count (fail_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.u_evt.ev_valid) ev_count++;
        if (measure && led == LED_RED) red_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic b, input int gap);
        if (b) btn_b_n = 1'b0;
        else   btn_a_n = 1'b0;
        tick(4);
        btn_a_n = 1'b1;
        btn_b_n = 1'b1;
        tick(gap);
    endtask

    task automatic enter(input logic [5:0] c);
        for (int i = 0; i < 6; i++) press(c[i], 4);
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_a_n = 1'b1;
        btn_b_n = 1'b1;
        tick(3);
        check("rst_state", state_dbg, 0);
        check("rst_led", led, 3'b111);
        check("rst_unlocked", unlocked, 0);
        check("rst_locked_out", locked_out, 0);
        check("rst_fail_count", fail_count, 0);
        rst_n = 1'b1;
        tick(2);

        // Enrol A,B,B,A,B,A -> code 6'b010110, then VERIFY blinks cyan every 4 cycles
        enter(6'b010110);
        check("enroll_state", state_dbg, 1);
        check("enroll_led_on", led, LED_CYAN);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check($sformatf("blink_%0d", i), led, ((i / 4) % 2 == 0) ? LED_OFF : LED_CYAN);
        end

        vecs.push_back('{0, 6'b010110, 2, 1, 0, 0, 1'b1, LED_GREEN});
        vecs.push_back('{1, 6'b000000, 1, 0, 0, 0, 1'b0, LED_OFF});
        vecs.push_back('{0, 6'b000000, 3, 0, 0, 1, 1'b1, LED_RED});
        vecs.push_back('{2, 6'b000000, 1, 0, 0, 1, 1'b0, LED_OFF});
        vecs.push_back('{0, 6'b110110, 3, 0, 0, 2, 1'b1, LED_RED});
        vecs.push_back('{2, 6'b000000, 1, 0, 0, 2, 1'b0, LED_OFF});
        vecs.push_back('{0, 6'b111111, 4, 0, 1, 3, 1'b1, LED_RED});
        vecs.push_back('{1, 6'b000001, 4, 0, 1, 3, 1'b0, LED_OFF});
        vecs.push_back('{2, 6'b000000, 1, 0, 0, 0, 1'b0, LED_OFF});
        vecs.push_back('{0, 6'b010110, 2, 1, 0, 0, 1'b1, LED_GREEN});
        vecs.push_back('{1, 6'b000001, 1, 0, 0, 0, 1'b0, LED_OFF});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            case (v.kind)
                0:       enter(v.val);
                1:       press(v.val[0], 4);
                default: tick(8);
            endcase
            check($sformatf("v%0d_state", i), state_dbg, v.st);
            check($sformatf("v%0d_unlocked", i), unlocked, v.unl);
            check($sformatf("v%0d_locked_out", i), locked_out, v.lo);
            check($sformatf("v%0d_fail_count", i), fail_count, v.fc);
            if (v.led_chk) check($sformatf("v%0d_led", i), led, v.led);
        end

        // DENIED holds red for exactly 8 cycles and swallows a press made during it
        for (int i = 0; i < 5; i++) press(1'b0, 4);
        press(1'b0, 0);
        red_cnt = 0;
        measure = 1'b1;
        tick(1);
        e0 = ev_count;
        btn_b_n = 1'b0;
        tick(4);
        btn_b_n = 1'b1;
        tick(20);
        measure = 1'b0;
        check("deny_red_cycles", red_cnt, DENY_CYCLES);
        check("deny_press_event", ev_count - e0, 1);
        check("deny_exit_state", state_dbg, 1);
        check("deny_fail_count", fail_count, 1);
        enter(6'b010110);
        check("deny_not_buffered", state_dbg, 2);
        check("grant_clears_fails", fail_count, 0);
        press(1'b0, 4);
        check("relock_state", state_dbg, 1);

        // Button hygiene in VERIFY with an empty entry
        e0 = ev_count;
        btn_a_n = 1'b0;
        tick(100);
        btn_a_n = 1'b1;
        tick(6);
        check("held_press_events", ev_count - e0, 1);
        e0 = ev_count;
        btn_a_n = 1'b0;
        btn_b_n = 1'b0;
        tick(10);
        btn_a_n = 1'b1;
        btn_b_n = 1'b1;
        tick(6);
        check("both_low_events", ev_count - e0, 0);
        e0 = ev_count;
        btn_a_n = 1'b0;
        tick(6);
        btn_b_n = 1'b0;
        tick(4);
        btn_a_n = 1'b1;
        tick(4);
        btn_a_n = 1'b0;
        tick(6);
        btn_a_n = 1'b1;
        btn_b_n = 1'b1;
        tick(6);
        check("no_rearm_events", ev_count - e0, 1);
        press(1'b1, 4);
        check("partial_state", state_dbg, 1);

        // Three bits pending; idle timeout must discard them before the next entry
        tick(60);
        enter(6'b010110);
        check("idle_clear_grant", state_dbg, 2);
        check("idle_clear_unlocked", unlocked, 1);
        press(1'b1, 4);
        check("relock2_state", state_dbg, 1);

        // Reset mid-entry with a nonzero fail count
        enter(6'b000000);
        check("pre_rst_fail_count", fail_count, 1);
        tick(10);
        press(1'b0, 4);
        press(1'b1, 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_led", led, 3'b111);
        check("mid_rst_unlocked", unlocked, 0);
        check("mid_rst_locked_out", locked_out, 0);
        check("mid_rst_fail_count", fail_count, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_state", state_dbg, 0);
        enter(6'b111000);
        check("reenroll_state", state_dbg, 1);
        enter(6'b010110);
        check("old_code_lost", state_dbg, 3);
        check("old_code_fail_count", fail_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
